// File: rtl/mmio_bus_pkg.sv
// Shared encodings for the mmio load/store port: access sizes, arbiter states
// and the BRAM/GPIO split address.
package mmio_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [31:0] GPIO_BASE = 32'h0000_1000;
  localparam int          CNT_W     = 4;

endpackage

// File: rtl/mmio_size_decode.sv
// Combinational {we, size, unsigned, valid} -> one-hot is_* strobes for the mmio
// port. Also used by the core's load/store unit.
module mmio_size_decode (
  input  logic       we,
  input  logic [1:0] size,
  input  logic       is_unsigned,
  input  logic       valid,
  output logic       is_lb,
  output logic       is_lbu,
  output logic       is_lh,
  output logic       is_lhu,
  output logic       is_lw,
  output logic       is_sb,
  output logic       is_sh,
  output logic       is_sw
);
  import mmio_bus_pkg::*;

  always_comb begin
    is_lb  = 1'b0;
    is_lbu = 1'b0;
    is_lh  = 1'b0;
    is_lhu = 1'b0;
    is_lw  = 1'b0;
    is_sb  = 1'b0;
    is_sh  = 1'b0;
    is_sw  = 1'b0;
    if (valid) begin
      case (size_e'(size))
        SIZE_BYTE: begin
          if (we) is_sb = 1'b1;
          else if (is_unsigned) is_lbu = 1'b1;
          else is_lb = 1'b1;
        end
        SIZE_HALF: begin
          if (we) is_sh = 1'b1;
          else if (is_unsigned) is_lhu = 1'b1;
          else is_lh = 1'b1;
        end
        // Word loads have no sign variant; is_unsigned is irrelevant here.
        SIZE_WORD: begin
          if (we) is_sw = 1'b1;
          else is_lw = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the mmio load/store
// port; boot_mode hands master 1 strict priority and stalls the core.
module mmio_arbiter #(
  parameter int ACCESS_CYCLES = 1,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_mode,
  output logic              cpu_hold,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic              m0_unsigned,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic              m1_unsigned,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  output logic              bus_load_enable,
  output logic              bus_store_enable,
  output logic              bus_is_lb,
  output logic              bus_is_lbu,
  output logic              bus_is_lh,
  output logic              bus_is_lhu,
  output logic              bus_is_lw,
  output logic              bus_is_sb,
  output logic              bus_is_sh,
  output logic              bus_is_sw,
  output logic [ADDR_W-1:0] bus_address,
  output logic [31:0]       bus_data_in,
  input  logic [31:0]       bus_data_out,
  output logic              err
);
  import mmio_bus_pkg::*;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d;
  logic [31:0]       m1_rdata_q, m1_rdata_d;

  logic              el0, el1, pick;
  logic [31:0]       resp_data;
  logic              access_first, xfer_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    pick         = 1'b0;
    resp_data    = '0;
    // A master only sees its ack in the ack cycle, so its req is still high
    // then; masking it stops the finished transfer from being re-granted.
    el0 = m0_req & ~m0_ack_q & ~boot_mode;
    el1 = m1_req & ~m1_ack_q;

    case (state_q)
      IDLE: begin
        if (el0 | el1) begin
          pick         = (el0 & el1) ? ~last_grant_q : el1;
          gnt_d        = pick;
          last_grant_d = pick;
          cnt_d        = CNT_INIT;
          state_d      = ACCESS;
          if (pick) begin
            we_d    = m1_we;
            size_d  = m1_size;
            uns_d   = m1_unsigned;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
          end else begin
            we_d    = m0_we;
            size_d  = m0_size;
            uns_d   = m0_unsigned;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
          end
          if (size_d == SIZE_RSVD) err_d = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = RESP;
        else cnt_d = cnt_q - 1'b1;
      end
      RESP: begin
        resp_data = (we_q || size_q == SIZE_RSVD) ? 32'd0 : bus_data_out;
        if (gnt_q) begin
          m1_rdata_d = resp_data;
          m1_ack_d   = 1'b1;
        end else begin
          m0_rdata_d = resp_data;
          m0_ack_d   = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Enables and strobes fire only in the first ACCESS cycle (counter untouched).
  assign access_first = (state_q == ACCESS) && (cnt_q == CNT_INIT);
  assign xfer_ok      = access_first && (size_q != SIZE_RSVD);

  assign bus_load_enable  = xfer_ok & ~we_q;
  assign bus_store_enable = xfer_ok & we_q;
  assign bus_address      = (state_q == ACCESS) ? addr_q : '0;
  assign bus_data_in      = (state_q == ACCESS) ? wdata_q : 32'd0;

  mmio_size_decode u_size_decode (
    .we          (we_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .valid       (xfer_ok),
    .is_lb       (bus_is_lb),
    .is_lbu      (bus_is_lbu),
    .is_lh       (bus_is_lh),
    .is_lhu      (bus_is_lhu),
    .is_lw       (bus_is_lw),
    .is_sb       (bus_is_sb),
    .is_sh       (bus_is_sh),
    .is_sw       (bus_is_sw)
  );

  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign err      = err_q;
  assign cpu_hold = boot_mode | (m0_req & ~m0_ack_q);

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter: scoreboard of expected acks plus
// per-scenario timing and strobe checks.
module tb_mmio_arbiter;
  import mmio_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_mode;
  logic        m0_req, m0_we, m0_unsigned, m1_req, m1_we, m1_unsigned;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_data_out;

  logic        cpu_hold, m0_ack, m1_ack, bus_load_enable, bus_store_enable, err;
  logic [31:0] m0_rdata, m1_rdata, bus_address, bus_data_in;
  logic        bus_is_lb, bus_is_lbu, bus_is_lh, bus_is_lhu, bus_is_lw, bus_is_sb, bus_is_sh, bus_is_sw;

  logic        cpu_hold_4, m0_ack_4, m1_ack_4, bus_load_enable_4, bus_store_enable_4, err_4;
  logic [31:0] m0_rdata_4, m1_rdata_4, bus_address_4, bus_data_in_4;
  logic        lb_4, lbu_4, lh_4, lhu_4, lw_4, sb_4, sh_4, sw_4;

  wire [7:0]   strb = {bus_is_lb, bus_is_lbu, bus_is_lh, bus_is_lhu, bus_is_lw, bus_is_sb, bus_is_sh, bus_is_sw};
  wire [141:0] outs_1 = {cpu_hold, m0_ack, m0_rdata, m1_ack, m1_rdata, bus_load_enable, bus_store_enable,
                         strb, bus_address, bus_data_in, err};
  wire [141:0] outs_4 = {cpu_hold_4, m0_ack_4, m0_rdata_4, m1_ack_4, m1_rdata_4, bus_load_enable_4,
                         bus_store_enable_4, lb_4, lbu_4, lh_4, lhu_4, lw_4, sb_4, sh_4, sw_4,
                         bus_address_4, bus_data_in_4, err_4};

  typedef struct packed {
    logic        master;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b1;

  always #5 clk = ~clk;

  mmio_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .boot_mode(boot_mode), .cpu_hold(cpu_hold),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_unsigned(m0_unsigned),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_unsigned(m1_unsigned),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_load_enable(bus_load_enable), .bus_store_enable(bus_store_enable),
    .bus_is_lb(bus_is_lb), .bus_is_lbu(bus_is_lbu), .bus_is_lh(bus_is_lh), .bus_is_lhu(bus_is_lhu),
    .bus_is_lw(bus_is_lw), .bus_is_sb(bus_is_sb), .bus_is_sh(bus_is_sh), .bus_is_sw(bus_is_sw),
    .bus_address(bus_address), .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .err(err)
  );

  mmio_arbiter #(.ACCESS_CYCLES(4), .ADDR_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .boot_mode(boot_mode), .cpu_hold(cpu_hold_4),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_unsigned(m0_unsigned),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack_4), .m0_rdata(m0_rdata_4),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_unsigned(m1_unsigned),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack_4), .m1_rdata(m1_rdata_4),
    .bus_load_enable(bus_load_enable_4), .bus_store_enable(bus_store_enable_4),
    .bus_is_lb(lb_4), .bus_is_lbu(lbu_4), .bus_is_lh(lh_4), .bus_is_lhu(lhu_4),
    .bus_is_lw(lw_4), .bus_is_sb(sb_4), .bus_is_sh(sh_4), .bus_is_sw(sw_4),
    .bus_address(bus_address_4), .bus_data_in(bus_data_in_4), .bus_data_out(bus_data_out), .err(err_4)
  );

  // Scoreboard: every ack of the ACCESS_CYCLES=1 instance must match the next expected entry.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (bus_load_enable && bus_store_enable) begin
        checks++;
        errors++;
        $display("FAIL both_enables load=%b store=%b required one at most", bus_load_enable, bus_store_enable);
      end
      if (m0_ack || m1_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_ack m0_ack=%b m1_ack=%b required no ack", m0_ack, m1_ack);
        end else begin
          exp_t e;
          logic [31:0] rd;
          e  = exp_q.pop_front();
          rd = m1_ack ? m1_rdata : m0_rdata;
          if ((m0_ack && m1_ack) || m1_ack !== e.master || rd !== e.rdata) begin
            errors++;
            $display("FAIL sb_ack got master=%0d rdata=%h required master=%0d rdata=%h",
                     m1_ack, rd, e.master, e.rdata);
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    boot_mode = 0; m0_req = 0; m1_req = 0;
    m0_we = 0; m0_size = 0; m0_unsigned = 0; m0_addr = 0; m0_wdata = 0;
    m1_we = 0; m1_size = 0; m1_unsigned = 0; m1_addr = 0; m1_wdata = 0;
    bus_data_out = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    checks++;
    if (outs_1 !== '0) begin errors++; $display("FAIL reset_outs_async got %h required 0", outs_1); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outs_4 !== '0) begin errors++; $display("FAIL reset_outs_dut4 got %h required 0", outs_4); end
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outs_1 !== '0) begin errors++; $display("FAIL idle_after_reset got %h required 0", outs_1); end
  endtask

  task automatic test_load_word();
    int ack_at = -1, le_n = 0, lw_n = 0;
    @(posedge clk); #1;
    m0_we = 0; m0_size = 2; m0_unsigned = 0; m0_addr = 32'h10; bus_data_out = 32'hDEADBEEF;
    m0_req = 1;
    exp_q.push_back('{master: 1'b0, rdata: 32'hDEADBEEF});
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus_load_enable) le_n++;
      if (bus_load_enable && strb === 8'b0000_1000) lw_n++;
      if (m0_ack && ack_at < 0) begin ack_at = i; m0_req = 0; end
    end
    checks++;
    if (le_n !== 1) begin errors++; $display("FAIL lw_enable_cycles got %0d required 1", le_n); end
    checks++;
    if (lw_n !== 1) begin errors++; $display("FAIL lw_strobe_cycles got %0d required 1", lw_n); end
    checks++;
    if (ack_at !== 3) begin errors++; $display("FAIL lw_latency got %0d required 3", ack_at); end
    checks++;
    if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata_hold got %h required deadbeef", m0_rdata); end
  endtask

  task automatic test_round_robin();
    int n0 = 0, n1 = 0, seq_bad = 0, both_en = 0, first = -1, last = -1;
    reset_dut();
    m0_we = 1; m0_size = 2; m0_addr = 32'h20; m0_wdata = 32'h1111_1111;
    m1_we = 1; m1_size = 2; m1_addr = 32'h24; m1_wdata = 32'h2222_2222;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{master: 1'b0, rdata: 32'd0});
      exp_q.push_back('{master: 1'b1, rdata: 32'd0});
    end
    m0_req = 1; m1_req = 1;
    for (int cyc = 0; cyc < 80 && (n0 < 3 || n1 < 3); cyc++) begin
      @(posedge clk); #1;
      if (bus_load_enable && bus_store_enable) both_en++;
      if (m0_ack) begin
        m0_req = 0; n0++;
        if (first < 0) first = 0;
        if (last == 0) seq_bad++;
        last = 0;
      end else if (!m0_req && n0 < 3) m0_req = 1;
      if (m1_ack) begin
        m1_req = 0; n1++;
        if (first < 0) first = 1;
        if (last == 1) seq_bad++;
        last = 1;
      end else if (!m1_req && n1 < 3) m1_req = 1;
    end
    m0_req = 0; m1_req = 0;
    checks++;
    if (n0 !== 3 || n1 !== 3) begin errors++; $display("FAIL rr_ack_count got %0d/%0d required 3/3", n0, n1); end
    checks++;
    if (first !== 0) begin errors++; $display("FAIL rr_first_grant got m%0d required m0", first); end
    checks++;
    if (seq_bad !== 0) begin errors++; $display("FAIL rr_alternation got %0d repeats required 0", seq_bad); end
    checks++;
    if (both_en !== 0) begin errors++; $display("FAIL rr_both_enables got %0d cycles required 0", both_en); end
  endtask

  task automatic test_boot_mode();
    int k = 0, hold_bad = 0, addr_bad = 0, drop_cyc = -1, m0_at = -1;
    @(posedge clk); #1;
    boot_mode = 1;
    m0_we = 0; m0_size = 2; m0_addr = 32'h80; bus_data_out = 32'h1234_5678;
    m1_we = 1; m1_size = 2; m1_addr = 32'h0; m1_wdata = 32'd0;
    for (int i = 0; i < 16; i++) exp_q.push_back('{master: 1'b1, rdata: 32'd0});
    exp_q.push_back('{master: 1'b0, rdata: 32'h1234_5678});
    m0_req = 1; m1_req = 1;
    #1;
    checks++;
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL boot_cpu_hold got %b required 1", cpu_hold); end
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      if (boot_mode && !cpu_hold) hold_bad++;
      if (bus_store_enable && bus_address !== 32'(4 * k)) addr_bad++;
      if (m0_ack) begin m0_req = 0; m0_at = cyc; break; end
      if (m1_ack) begin
        m1_req = 0; k++;
        if (k == 16) begin boot_mode = 0; drop_cyc = cyc; end
      end else if (!m1_req && k < 16) begin
        m1_addr = 32'(4 * k); m1_wdata = 32'(k); m1_req = 1;
      end
    end
    boot_mode = 0; m0_req = 0; m1_req = 0;
    checks++;
    if (k !== 16) begin errors++; $display("FAIL boot_m1_stores got %0d required 16", k); end
    checks++;
    if (hold_bad !== 0) begin errors++; $display("FAIL boot_hold_cycles got %0d drops required 0", hold_bad); end
    checks++;
    if (addr_bad !== 0) begin errors++; $display("FAIL boot_store_addr got %0d bad required 0", addr_bad); end
    checks++;
    if (m0_at < 0 || drop_cyc < 0 || m0_at - drop_cyc > 3) begin
      errors++; $display("FAIL boot_m0_after_drop got %0d cycles required <=3", m0_at - drop_cyc);
    end
    #1;
    checks++;
    if (cpu_hold !== 1'b0) begin errors++; $display("FAIL boot_hold_release got %b required 0", cpu_hold); end
  endtask

  task automatic test_store_half();
    int seen = 0, bad = 0, acked = 0;
    @(posedge clk); #1;
    m1_we = 0; m1_size = 2; m1_addr = GPIO_BASE + 32'h4; bus_data_out = 32'hCAFE_F00D; m1_req = 1;
    exp_q.push_back('{master: 1'b1, rdata: 32'hCAFE_F00D});
    for (int i = 0; i < 10 && acked == 0; i++) begin
      @(posedge clk); #1;
      if (m1_ack) begin m1_req = 0; acked = 1; end
    end
    checks++;
    if (m1_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL m1_load_rdata got %h required cafef00d", m1_rdata); end
    @(posedge clk); #1;
    m1_we = 1; m1_size = 1; m1_addr = GPIO_BASE; m1_wdata = 32'h0000_A5A5; m1_req = 1;
    exp_q.push_back('{master: 1'b1, rdata: 32'd0});
    acked = 0;
    for (int i = 0; i < 10 && acked == 0; i++) begin
      @(posedge clk); #1;
      if (bus_store_enable) begin
        seen++;
        if (strb !== 8'b0000_0010 || bus_address !== 32'h1000 || bus_data_in !== 32'h0000_A5A5) bad++;
      end
      if (m1_ack) begin m1_req = 0; acked = 1; end
    end
    checks++;
    if (seen !== 1 || bad !== 0) begin errors++; $display("FAIL sh_bus got seen=%0d bad=%0d required 1/0", seen, bad); end
    checks++;
    if (m1_rdata !== 32'd0) begin errors++; $display("FAIL sh_rdata got %h required 0", m1_rdata); end
  endtask

  task automatic test_reserved();
    int ack_at = -1, en_bad = 0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_initial got %b required 0", err); end
    @(posedge clk); #1;
    m0_we = 0; m0_size = 3; m0_addr = 32'h44; bus_data_out = 32'hFFFF_FFFF; m0_req = 1;
    exp_q.push_back('{master: 1'b0, rdata: 32'd0});
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus_load_enable || bus_store_enable || strb !== 8'd0) en_bad++;
      if (m0_ack && ack_at < 0) begin ack_at = i; m0_req = 0; end
    end
    checks++;
    if (en_bad !== 0) begin errors++; $display("FAIL rsvd_no_enables got %0d cycles required 0", en_bad); end
    checks++;
    if (ack_at !== 3) begin errors++; $display("FAIL rsvd_ack got %0d required 3", ack_at); end
    checks++;
    if (m0_rdata !== 32'd0) begin errors++; $display("FAIL rsvd_rdata got %h required 0", m0_rdata); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b required 1", err); end
    rst_n = 0;
    #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_reset_clear got %b required 0", err); end
    reset_dut();
  endtask

  task automatic test_reset_mid_access();
    int ack_seen = 0, ack_at = -1;
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_leftover got %0d required 0", exp_q.size()); end
    mon_en = 0;
    exp_q.delete();
    reset_dut();
    @(posedge clk); #1;
    m0_we = 0; m0_size = 2; m0_addr = 32'h40; bus_data_out = 32'h55AA_55AA; m0_req = 1;
    @(posedge clk); #1;
    checks++;
    if (bus_load_enable_4 !== 1'b1) begin errors++; $display("FAIL ac4_enable got %b required 1", bus_load_enable_4); end
    @(posedge clk); #2;
    rst_n = 0;
    m0_req = 0;
    #1;
    checks++;
    if (outs_4 !== '0) begin errors++; $display("FAIL ac4_async_reset got %h required 0", outs_4); end
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (m0_ack_4) ack_seen++;
    end
    checks++;
    if (ack_seen !== 0) begin errors++; $display("FAIL ac4_lost_xfer got %0d acks required 0", ack_seen); end
    m0_addr = 32'h48; bus_data_out = 32'h0BAD_F00D; m0_req = 1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (m0_ack_4 && ack_at < 0) begin ack_at = i; m0_req = 0; end
    end
    checks++;
    if (ack_at !== 6) begin errors++; $display("FAIL ac4_latency got %0d required 6", ack_at); end
    checks++;
    if (m0_rdata_4 !== 32'h0BAD_F00D) begin errors++; $display("FAIL ac4_rdata got %h required 0badf00d", m0_rdata_4); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_word();
    test_round_robin();
    test_boot_mode();
    test_store_half();
    test_reserved();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
